// File: rtl/mod_game_pkg.sv
// Shared types and widths for the Modulus Game round logic.
package mod_game_pkg;

  localparam int DIVIDEND_W = 7;
  localparam int DIVISOR_W  = 4;
  localparam int SCORE_W    = 4;

  localparam logic [DIVIDEND_W-1:0] DIVIDEND_MAX = 7'd99;

  typedef enum logic [3:0] {
    IDLE,
    GAP_A,
    DRAW_A,
    GAP_B,
    DRAW_B,
    CALC,
    PRESENT,
    JUDGE,
    DONE
  } state_t;

endpackage

// File: rtl/mod_remainder.sv
// Iterative remainder by repeated subtraction; operands load on start.
module mod_remainder
  import mod_game_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic [DIVIDEND_W-1:0] rem,
  output logic                  done
);

  logic [DIVIDEND_W-1:0] rem_q;
  logic [DIVISOR_W-1:0]  div_q;
  logic                  run;
  logic                  ge;

  assign ge   = rem_q >= {{(DIVIDEND_W-DIVISOR_W){1'b0}}, div_q};
  assign done = run && !ge;
  assign rem  = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      div_q <= '0;
      run   <= 1'b0;
    end else if (start) begin
      rem_q <= a;
      div_q <= b;
      run   <= 1'b1;
    end else if (run) begin
      if (ge) rem_q <= rem_q - {{(DIVIDEND_W-DIVISOR_W){1'b0}}, div_q};
      else    run   <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_round_ctrl.sv
// Round sequencer: draws dividend/divisor from the RNG, computes the
// remainder, presents the problem, judges guesses and keeps score.
module mod_round_ctrl
  import mod_game_pkg::*;
#(
  parameter int unsigned DRAW_GAP   = 7,
  parameter int unsigned MIN_DIV    = 2,
  parameter int unsigned MAX_DIV    = 12,
  parameter int unsigned MAX_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_game,
  input  logic [DIVIDEND_W-1:0] rand_in,
  input  logic                  guess_valid,
  input  logic [DIVIDEND_W-1:0] guess,
  output logic [DIVIDEND_W-1:0] dividend,
  output logic [DIVISOR_W-1:0]  divisor,
  output logic                  problem_valid,
  output logic                  result_valid,
  output logic                  result_correct,
  output logic [SCORE_W-1:0]    score,
  output logic [SCORE_W-1:0]    round_cnt,
  output logic                  busy,
  output logic                  game_over
);

  localparam logic [3:0]           GAP_LOAD = 4'(DRAW_GAP - 1);
  localparam logic [DIVISOR_W-1:0] MIN_D    = DIVISOR_W'(MIN_DIV);
  localparam logic [DIVISOR_W-1:0] MAX_D    = DIVISOR_W'(MAX_DIV);
  localparam logic [SCORE_W-1:0]   ROUNDS   = SCORE_W'(MAX_ROUNDS);

  state_t                state;
  logic [3:0]            gap;
  logic [DIVIDEND_W-1:0] guess_q;
  logic [DIVIDEND_W-1:0] rem;
  logic                  rem_done;
  logic [DIVISOR_W-1:0]  cand;
  logic                  div_ok;
  logic                  rem_start;

  assign cand      = rand_in[DIVISOR_W-1:0];
  assign div_ok    = (cand >= MIN_D) && (cand <= MAX_D);
  // The remainder unit loads on the same edge the divisor is latched, so CALC needs no setup cycle.
  assign rem_start = (state == DRAW_B) && div_ok && !start_game;

  mod_remainder u_rem (
    .clk   (clk),
    .rst   (rst),
    .start (rem_start),
    .a     (dividend),
    .b     (cand),
    .rem   (rem),
    .done  (rem_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gap            <= '0;
      guess_q        <= '0;
      dividend       <= '0;
      divisor        <= '0;
      problem_valid  <= 1'b0;
      result_valid   <= 1'b0;
      result_correct <= 1'b0;
      score          <= '0;
      round_cnt      <= '0;
      busy           <= 1'b0;
      game_over      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (start_game) begin
        state         <= GAP_A;
        gap           <= GAP_LOAD;
        score         <= '0;
        round_cnt     <= '0;
        problem_valid <= 1'b0;
        busy          <= 1'b1;
        game_over     <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          GAP_A: begin
            if (gap == '0) state <= DRAW_A;
            else           gap   <= gap - 4'd1;
          end
          DRAW_A: begin
            gap <= GAP_LOAD;
            if (rand_in <= DIVIDEND_MAX) begin
              dividend <= rand_in;
              state    <= GAP_B;
            end else begin
              state <= GAP_A;
            end
          end
          GAP_B: begin
            if (gap == '0) state <= DRAW_B;
            else           gap   <= gap - 4'd1;
          end
          DRAW_B: begin
            if (div_ok) begin
              divisor <= cand;
              state   <= CALC;
            end else begin
              gap   <= GAP_LOAD;
              state <= GAP_B;
            end
          end
          CALC: begin
            if (rem_done) begin
              problem_valid <= 1'b1;
              state         <= PRESENT;
            end
          end
          PRESENT: begin
            if (guess_valid) begin
              guess_q       <= guess;
              problem_valid <= 1'b0;
              state         <= JUDGE;
            end
          end
          JUDGE: begin
            result_valid   <= 1'b1;
            result_correct <= (guess_q == rem);
            if (guess_q == rem) score <= score + 1'b1;
            round_cnt <= round_cnt + 1'b1;
            if (round_cnt + 1'b1 == ROUNDS) begin
              state     <= DONE;
              busy      <= 1'b0;
              game_over <= 1'b1;
            end else begin
              state <= GAP_A;
              gap   <= GAP_LOAD;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mod_round_ctrl.md
# mod_round_ctrl

Round sequencer for the Modulus Game. It samples the free-running 7-bit random source at spaced intervals to draw a dividend (0–99) and a divisor (MIN_DIV–MAX_DIV), and computes the remainder by iterative subtraction. It then presents the problem to the display/input logic, judges the player's guess, keeps score and ends the game after MAX_ROUNDS rounds. It sits between the RNG instance and the top-level game/display logic.

## Interface
- DRAW_GAP, 7: cycles waited before each random sample; decorrelates successive LFSR draws; range 1–15.
- MIN_DIV, 2: smallest legal divisor.
- MAX_DIV, 12: largest legal divisor; must be ≤15.
- MAX_ROUNDS, 10: rounds per game; range 1–15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_game  in  1  one-cycle pulse; starts a new game from any state.
- rand_in  in  7  output of the RNG; nominally 0–99.
- guess_valid  in  1  one-cycle pulse; guess is valid.
- guess  in  7  player's remainder guess.
- dividend  out  7  current dividend.
- divisor  out  4  current divisor.
- problem_valid  out  1  high while waiting for a guess.
- result_valid  out  1  one-cycle pulse after each judged guess.
- result_correct  out  1  judgment; meaningful only with result_valid.
- score  out  4  count of correct guesses this game.
- round_cnt  out  4  count of rounds completed this game.
- busy  out  1  high in every state except IDLE and DONE.
- game_over  out  1  high in DONE.

## Operation
- States: IDLE, GAP_A, DRAW_A, GAP_B, DRAW_B, CALC, PRESENT, JUDGE, DONE.
- IDLE: all outputs 0. start_game leads to GAP_A and clears score and round_cnt.
- GAP_x: gap counter is loaded with DRAW_GAP−1 on entry and decrements each cycle. At 0 the state moves to DRAW_x. Each gap therefore lasts exactly DRAW_GAP cycles.
- DRAW_A: samples rand_in.
  - If rand_in ≤ 99, it is latched into dividend and the state moves to GAP_B.
  - Otherwise the sample is rejected and the state returns to GAP_A.
- DRAW_B: takes the candidate rand_in[3:0].
  - If MIN_DIV ≤ candidate ≤ MAX_DIV, it is latched into divisor and the state moves to CALC.
  - Otherwise the state returns to GAP_B. dividend is kept.
- CALC: rem is initialised to dividend. Each cycle, if rem ≥ divisor then rem ← rem − divisor; otherwise the state moves to PRESENT.
  - This takes floor(dividend/divisor)+1 cycles, at most 50.
  - Arithmetic is 7-bit unsigned and never underflows.
- PRESENT: problem_valid=1. The state waits indefinitely for guess_valid, which leads to JUDGE with guess latched.
- JUDGE (1 cycle): the registered outputs result_valid and result_correct (= guess==rem) are asserted in the following cycle.
  - A correct guess increments score. round_cnt increments on every judged guess.
  - If the new round_cnt equals MAX_ROUNDS, the state moves to DONE; otherwise to GAP_A.
- DONE: game_over=1. dividend, divisor, score and round_cnt are held. start_game leads to GAP_A and clears the counters.
- guess_valid outside PRESENT is ignored.
- start_game in any non-IDLE state restarts the game: score and round_cnt are cleared, problem_valid drops and the state moves to GAP_A.
- rst overrides start_game. start_game overrides guess_valid in the same cycle.

## Timing
- Reset value of every output and register is 0; state is IDLE.
- All outputs are registered and none depends combinationally on inputs.
- Given start_game sampled at edge E0, with no rejections, problem_valid rises at edge E0 + 2·(DRAW_GAP+1) + floor(dividend/divisor) + 1.
- Each rejection adds DRAW_GAP+1 cycles.
- Given guess_valid sampled at edge G0:
  - problem_valid falls at G0.
  - result_valid is high for exactly the one cycle following edge G0+1.
  - score and round_cnt update at G0+1.
  - The next GAP_A, or DONE, begins at G0+1.
- dividend and divisor are stable from their latch edge until the next latch in DRAW_A/DRAW_B of the following round.

## Structure
- Package mod_game_pkg holds:
  - the state enum typedef;
  - DIVIDEND_W=7, DIVISOR_W=4, SCORE_W=4;
  - the legal dividend ceiling 99.
- Sub-module mod_remainder is natural: an iterative remainder unit with a start/done handshake, driven from CALC.
- FSM, gap counter, score and round counters live in mod_round_ctrl.

## Test plan
- Basic round: MAX_ROUNDS=10, DRAW_GAP=7. Bench drives rand_in=37 at DRAW_A and 5 at DRAW_B.
  - Expected: dividend=37, divisor=5, problem_valid at E0+24.
  - guess=2 → result_correct=1, score=1, round_cnt=1.
- Wrong guess: 99 % 12 = 3, guess=4 → result_correct=0, score unchanged, round_cnt increments.
- Rejection:
  - rand_in=120 at DRAW_A → redraw; next draw 40 is accepted.
  - Divisor draws 15 and then 1 are both rejected; 19 (low nibble 3) is accepted.
  - problem_valid is delayed by exactly 3·(DRAW_GAP+1) cycles.
- Game end: MAX_ROUNDS=3 with three correct guesses → game_over=1, score=3, busy=0.
  - Further guess_valid is ignored.
  - start_game → counters cleared, busy=1.
- Restart/reset:
  - start_game during CALC → score=0, round_cnt=0, state GAP_A.
  - rst during PRESENT → all outputs 0 next cycle.
  - rst and start_game in the same cycle → IDLE.
